// File: rtl/rr_dispatch.sv
// rr_dispatch: round-robin fan-out of one valid/ready job stream to credit-limited workers
module rr_dispatch #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PORTS-1:0]  port_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]  out_valid,
  input  logic [NUM_PORTS-1:0]  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [NUM_PORTS-1:0]  done,
  output logic                  idle,
  output logic                  err_credit
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL_CR = CW'(CREDITS);
  logic [NUM_PORTS-1:0] token, cand, sel, cr_full;
  logic [2*NUM_PORTS-1:0] dbl, gnt;
  logic [CW-1:0] credit [NUM_PORTS];
  logic full, fire_out, accept;
  always_comb begin
    cand = '0;
    cr_full = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand[i] = port_en[i] & (credit[i] != '0);
      cr_full[i] = credit[i] == FULL_CR;
    end
  end
  // doubled vector lets the borrow of a subtract find the first candidate at or after the token
  assign dbl = {cand, cand};
  assign gnt = dbl & ~(dbl - {{NUM_PORTS{1'b0}}, token});
  assign sel = gnt[NUM_PORTS-1:0] | gnt[2*NUM_PORTS-1:NUM_PORTS];
  assign full = |out_valid;
  assign fire_out = |(out_valid & out_ready);
  assign in_ready = ~rst & (|cand) & (~full | fire_out);
  assign accept = in_valid & in_ready;
  assign idle = ~full & (&cr_full);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data <= '0;
      token <= NUM_PORTS'(1);
      err_credit <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) credit[i] <= FULL_CR;
    end else begin
      if (accept) begin
        out_valid <= sel;
        out_data <= in_data;
        token <= {sel[NUM_PORTS-2:0], sel[NUM_PORTS-1]};
      end else if (fire_out) begin
        out_valid <= '0;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (done[i] && !(accept && sel[i])) begin
          if (credit[i] == FULL_CR) err_credit <= 1'b1;
          else credit[i] <= credit[i] + CW'(1);
        end else if (!done[i] && accept && sel[i]) begin
          credit[i] <= credit[i] - CW'(1);
        end
      end
    end
  end
endmodule

// File: doc/rr_dispatch.md
Name: rr_dispatch

Overview:
- Round-robin dispatcher: takes one valid/ready job stream and spreads the beats across NUM_PORTS workers. It is the fan-out counterpart of the arbiter's fan-in.
- Uses a one-hot rotating token to set priority, and keeps per-port credit counters so no worker is overfilled.
- Sits between a job producer and a bank of identical workers; each worker returns a `done` pulse per completed job.

Parameters:
- NUM_PORTS, 4, number of worker ports (≥2).
- DATA_WIDTH, 32, width of the job payload.
- CREDITS, 2, maximum outstanding jobs per worker (≥1); counter width is clog2(CREDITS+1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- port_en  input  NUM_PORTS  per-port enable; a cleared bit excludes that port from new selection.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  dispatcher can accept this cycle (combinational).
- in_data  input  DATA_WIDTH  producer payload.
- out_valid  output  NUM_PORTS  one-hot (or zero) beat valid to the destination worker (registered).
- out_ready  input  NUM_PORTS  per-worker ready.
- out_data  output  DATA_WIDTH  payload, shared by all ports (registered).
- done  input  NUM_PORTS  one-cycle pulse per job completed by a worker; returns one credit.
- idle  output  1  output register empty and every credit counter equal to CREDITS.
- err_credit  output  1  sticky flag: `done` seen on a port whose credit was already full.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0.
  - token=1 (port 0 highest priority).
  - all credits=CREDITS.
  - err_credit=0.
  - in_ready=0 while rst is high; idle=1 in the first cycle after reset.
- Candidate selection:
  - cand = port_en & (credit≠0), using registered credit values.
  - Scan cand in rotating order starting at the token bit: token, token<<1, …, wrapping at NUM_PORTS.
  - sel = the first set bit found (one-hot); sel=0 if cand=0.
- Output register:
  - full = |out_valid.
  - fire_out = |(out_valid & out_ready).
- in_ready = (|cand) & (~full | fire_out).
- Accept: when in_valid & in_ready,
  - next cycle: out_valid=sel, out_data=in_data;
  - token <= sel rotated left by 1 with wrap (the port after the winner gets top priority);
  - credit[sel] decrements.
- Latency and throughput:
  - Latency is exactly 1 cycle, accept to out_valid.
  - Sustained throughput is 1 beat/cycle while the destination's out_ready is held high and credits are available.
- Drain without refill: if fire_out and no accept, out_valid <= 0.
- Hold rule: while out_valid[d]=1 and out_ready[d]=0, out_valid and out_data stay unchanged. This holds even if port_en[d] drops; port_en affects only new selection.
- Token stays unchanged on cycles with no accept.
- Credits:
  - done[i] increments credit[i].
  - Decrement and done on the same port in the same cycle: net unchanged.
  - done[i] while credit[i]=CREDITS with no same-cycle decrement: counter saturates (unchanged) and err_credit <= 1.
  - err_credit clears only on rst.
  - A done arriving this cycle does not affect cand until the next cycle.
- Multiple done bits may be set in the same cycle; each port is handled independently.
- Reset mid-operation: any pending beat is discarded, token returns to port 0, all credits are restored, and err_credit clears.
- idle = ~full & (all credit == CREDITS); combinational from registers.

Test Plan:
- NUM_PORTS=4, CREDITS=2, all enabled and ready, after reset: send beats 0xA0..0xA3 back-to-back -> accepted on 4 consecutive cycles; out_valid = 0001, 0010, 0100, 1000 on the following cycles with matching data; in_ready stays 1.
- No done pulses, 9 beats offered -> 8 accepted (two per port); in_ready=0 for the 9th. Pulse done[2] -> 9th beat is accepted the next cycle and dispatched to port 2 (out_valid=0100).
- port_en=1010, 4 beats -> destinations are ports 1, 3, 1, 3; ports 0 and 2 never see out_valid.
- Beat pending to port 0 with out_ready[0]=0 for 5 cycles -> out_valid=0001 and out_data stable; in_ready=0. Raise out_ready[0] with in_valid high -> handoff and new accept in the same cycle, next beat appears on port 1.
- Pulse done[1] with credit[1]=2 -> err_credit=1 and stays 1, credit unchanged, idle still 1. Assert rst -> err_credit=0.
- Beat pending on port 3 with two credits consumed; assert rst for 1 cycle -> next cycle out_valid=0, idle=1; the next beat goes to port 0.
